pwm_gen_4b: RTL and testbench

PWM_GEN_4B -- requirements
Module: pwm_gen_4b

---
 rtl/pwm_gen_4b.sv | 78 +++++++
 tb/tb_pwm_gen_4b.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_4b.sv
// 4-bit PWM generator with a valid/ready duty handshake; new duty values take effect only at period wraps.
// Optional macro PWM_SYNC_EN adds a two-flop synchronizer on count_in (latency 2 -> 4 cycles).
module pwm_gen_4b (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] count_in,
   input  logic [3:0] duty_in,
   input  logic       duty_valid,
   output logic       duty_ready,
   output logic       pwm_out,
   output logic       wrap_pulse,
   output logic [3:0] duty_active
);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t     state;
   logic [3:0] count_s;
   logic [3:0] count_p;
   logic [3:0] shadow;
   logic [3:0] count_src;

`ifdef PWM_SYNC_EN
   logic [3:0] sync_1;
   logic [3:0] sync_2;

   // The upstream ripple counter may run off divided clocks, so retime it before use.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 4'd0;
         sync_2 <= 4'd0;
      end else begin
         sync_1 <= count_in;
         sync_2 <= sync_1;
      end
   end

   assign count_src = sync_2;
`else
   assign count_src = count_in;
`endif

   // A wrap is a fall to zero from a non-zero count, so a stalled zero never re-fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_s     <= 4'd0;
         count_p     <= 4'd0;
         wrap_pulse  <= 1'b0;
         pwm_out     <= 1'b0;
         duty_active <= 4'd0;
         shadow      <= 4'd0;
         state       <= IDLE;
      end else begin
         count_s    <= count_src;
         count_p    <= count_s;
         wrap_pulse <= (count_s == 4'd0) && (count_p != 4'd0);
         pwm_out    <= (count_s < duty_active);
         case (state)
            IDLE: begin
               if (duty_valid) begin
                  shadow <= duty_in;
                  state  <= PENDING;
               end
            end
            PENDING: begin
               if (wrap_pulse) begin
                  duty_active <= shadow;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign duty_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_pwm_gen_4b.sv
// Randomized self-checking bench for pwm_gen_4b against a history-based behavioural model.
// Honours PWM_SYNC_EN to match the DUT build.
module tb_pwm_gen_4b;

`ifdef PWM_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] count_in = 4'd0;
   logic [3:0] duty_in = 4'd0;
   logic       duty_valid = 1'b0;
   logic       duty_ready;
   logic       pwm_out;
   logic       wrap_pulse;
   logic [3:0] duty_active;

   int         checks = 0;
   int         errors = 0;
   int         hi_count = 0;
   logic [3:0] cnt = 4'd0;

   // Model: recent count history as seen by the block, plus handshake bookkeeping.
   int         m_hist [0:4];
   logic       m_pending = 1'b0;
   int         m_shadow = 0;
   int         m_duty = 0;
   logic       m_pwm = 1'b0;
   logic       m_wrap = 1'b0;

   pwm_gen_4b dut (
      .clk         (clk),
      .rst         (rst),
      .count_in    (count_in),
      .duty_in     (duty_in),
      .duty_valid  (duty_valid),
      .duty_ready  (duty_ready),
      .pwm_out     (pwm_out),
      .wrap_pulse  (wrap_pulse),
      .duty_active (duty_active)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the reference behaviour, driven by the inputs seen at that edge.
   task automatic modelEdge(input logic r, input logic [3:0] ci, input logic dv, input logic [3:0] di);
      int   cs;
      int   cp;
      logic nw;
      logic np;
      if (r) begin
         for (int k = 0; k < 5; k++) m_hist[k] = 0;
         m_pending = 1'b0;
         m_shadow  = 0;
         m_duty    = 0;
         m_pwm     = 1'b0;
         m_wrap    = 1'b0;
      end else begin
         cs = m_hist[LAT-1];
         cp = m_hist[LAT];
         nw = (cs == 0) && (cp != 0);
         np = (cs < m_duty);
         if (!m_pending && dv) begin
            m_pending = 1'b1;
            m_shadow  = int'(di);
         end else if (m_pending && m_wrap) begin
            m_duty    = m_shadow;
            m_pending = 1'b0;
         end
         m_wrap = nw;
         m_pwm  = np;
         for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = int'(ci);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] ci, input logic dv, input logic [3:0] di);
      rst        = r;
      count_in   = ci;
      duty_valid = dv;
      duty_in    = di;
      @(posedge clk);
      modelEdge(r, ci, dv, di);
      @(negedge clk);
      checkOutput("pwm_out", int'(pwm_out), int'(m_pwm));
      checkOutput("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
      checkOutput("duty_active", int'(duty_active), m_duty);
      checkOutput("duty_ready", int'(duty_ready), int'(!r && !m_pending));
      if (pwm_out) hi_count++;
   endtask

   task automatic runRamp(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, cnt, 1'b0, 4'd0);
         cnt = cnt + 4'd1;
      end
   endtask

   task automatic offerDuty(input logic [3:0] d);
      applyStimulus(1'b0, cnt, 1'b1, d);
      cnt = cnt + 4'd1;
   endtask

   initial begin
      for (int k = 0; k < 5; k++) m_hist[k] = 0;

      // Reset, then one clean ramp with duty 0.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd0, 1'b0, 4'd0);
      cnt = 4'd0;
      runRamp(20);

      // Duty 5, then measure one full period of highs.
      offerDuty(4'd5);
      runRamp(24);
      hi_count = 0;
      runRamp(16);
      checkOutput("hi_per_period_5", hi_count, 5);

      // Offer while pending is ignored.
      offerDuty(4'd9);
      offerDuty(4'd3);
      runRamp(24);

      // Accept in the same cycle as a wrap.
      for (int g = 0; g < 40 && !wrap_pulse; g++) runRamp(1);
      checkOutput("wrap_seen", int'(wrap_pulse), 1);
      offerDuty(4'd12);
      runRamp(36);

      // Duty 15 leaves exactly one low count per period.
      offerDuty(4'd15);
      runRamp(40);
      hi_count = 0;
      runRamp(16);
      checkOutput("hi_per_period_15", hi_count, 15);

      // Reset while pending discards the pending value.
      offerDuty(4'd7);
      runRamp(40);
      offerDuty(4'd2);
      runRamp(3);
      applyStimulus(1'b1, cnt, 1'b0, 4'd0);
      cnt = cnt + 4'd1;
      runRamp(24);

      // Randomized traffic: stalls, jumps, offers and occasional resets.
      for (int i = 0; i < 600; i++) begin
         int   pick;
         logic r;
         logic dv;
         pick = int'($urandom_range(0, 99));
         if (pick < 10)      cnt = cnt;
         else if (pick < 18) cnt = 4'($urandom_range(0, 15));
         else                cnt = cnt + 4'd1;
         r  = ($urandom_range(0, 99) < 2);
         dv = ($urandom_range(0, 99) < 25);
         applyStimulus(r, cnt, dv, 4'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
